qed_dup_engine: RTL and testbench

//  Parametrised SQED instruction duplication engine between instruction fetch and the IF/ID register.

---
 rtl/qed_pkg.sv | 29 ++
 rtl/qed_inst_fifo.sv | 45 ++++
 rtl/qed_dup_engine.sv | 191 +++++++++++++++++++
 tb/tb_qed_dup_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
// Shared constants for the SQED duplication engine: opcodes, NOP, field positions, states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package qed_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // addi x0,x0,0
    localparam logic [31:0] QED_NOP = 32'h0000_0013;

    // LSB positions of the register fields inside an instruction word
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic {
        ST_ORIG = 1'b0,
        ST_DUP  = 1'b1
    } qed_state_t;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/qed_inst_fifo.sv
// Instruction FIFO (DEPTH x W) recording original instructions for later replay.
// Latency: pushed word visible at the head on the next cycle; head is read combinationally.
// Backpressure: caller must not push when full or pop when empty; full/empty use an extra pointer MSB.
module qed_inst_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointer update; reset discards any stored entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers qualify them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/qed_dup_engine.sv
// SQED duplication engine: forwards QED-legal fetches (ORIG) and replays them register-remapped (DUP).
// Latency: 1 cycle from accept/pop to qed_inst_o; all instruction outputs are registered.
// Backpressure: stall_i or ~ena freezes everything; ifu_rdy_o low in DUP or when the FIFO is full.
// Optional feature macro: QED_MEM_DUP_EN (LOAD/STORE become legal and duplicates flag qed_mem_dup_o).
module qed_dup_engine
    import qed_pkg::*;
#(
    parameter int INST_W     = 32,
    parameter int DEPTH      = 16,
    parameter int REG_AW     = 5,
    parameter int DUP_OFFSET = 16,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [INST_W-1:0]        ifu_inst_i,
    input  logic                     ifu_vld_i,
    output logic                     ifu_rdy_o,
    input  logic                     exec_dup_i,
    input  logic                     stall_i,
    output logic [INST_W-1:0]        qed_inst_o,
    output logic                     qed_vld_o,
    output logic                     qed_is_dup_o,
    output logic                     qed_mem_dup_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o,
    output logic                     qed_ready_o,
    output logic                     overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [REG_AW-1:0] OFS = REG_AW'(DUP_OFFSET);

    qed_state_t          state;
    logic [INST_W-1:0]   inst_q;
    logic                vld_q;
    logic                is_dup_q;
    logic                mem_dup_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    orig_cnt;
    logic [CNT_W-1:0]    dup_cnt;

    logic                active;
    logic                legal;
    logic                push;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_cnt;
    logic [INST_W-1:0]   head;
    logic [INST_W-1:0]   dup_inst;
    logic                mem_dup_c;

    logic [6:0]          opc;
    logic [REG_AW-1:0]   f_rd;
    logic [REG_AW-1:0]   f_rs1;
    logic [REG_AW-1:0]   f_rs2;

    // Originals must live in the lower half of the register file
    function automatic logic reg_ok(input logic [REG_AW-1:0] r);
        return int'(r) < DUP_OFFSET;
    endfunction

    // x0 is hard-wired zero in both halves, so it is never moved
    function automatic logic [REG_AW-1:0] remap_reg(input logic [REG_AW-1:0] r);
        return (r == '0) ? r : r + OFS;
    endfunction

    assign opc   = ifu_inst_i[6:0];
    assign f_rd  = ifu_inst_i[RD_LSB  +: REG_AW];
    assign f_rs1 = ifu_inst_i[RS1_LSB +: REG_AW];
    assign f_rs2 = ifu_inst_i[RS2_LSB +: REG_AW];

    // Decide whether the fetched instruction may enter the QED stream
    always_comb begin
        legal = 1'b0;
        case (opc)
            OPC_OP:     legal = reg_ok(f_rd) && reg_ok(f_rs1) && reg_ok(f_rs2);
            OPC_OP_IMM: legal = reg_ok(f_rd) && reg_ok(f_rs1);
            OPC_LUI:    legal = reg_ok(f_rd);
`ifdef QED_MEM_DUP_EN
            OPC_LOAD:   legal = reg_ok(f_rd) && reg_ok(f_rs1);
            OPC_STORE:  legal = reg_ok(f_rs1) && reg_ok(f_rs2);
`endif
            default:    legal = 1'b0;
        endcase
    end

    assign active    = ena && !stall_i;
    assign ifu_rdy_o = active && (state == ST_ORIG) && !fifo_full;
    assign push      = ifu_rdy_o && ifu_vld_i && legal;
    assign drop      = active && (state == ST_ORIG) && ifu_vld_i && legal && fifo_full;
    assign pop       = active && (state == ST_DUP);

    qed_inst_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (ifu_inst_i),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Build the duplicate of the FIFO head: only fields the format actually uses are moved
    always_comb begin
        dup_inst = head;
        case (head[6:0])
            OPC_OP: begin
                dup_inst[RD_LSB  +: REG_AW] = remap_reg(head[RD_LSB  +: REG_AW]);
                dup_inst[RS1_LSB +: REG_AW] = remap_reg(head[RS1_LSB +: REG_AW]);
                dup_inst[RS2_LSB +: REG_AW] = remap_reg(head[RS2_LSB +: REG_AW]);
            end
            OPC_OP_IMM, OPC_LOAD: begin
                dup_inst[RD_LSB  +: REG_AW] = remap_reg(head[RD_LSB  +: REG_AW]);
                dup_inst[RS1_LSB +: REG_AW] = remap_reg(head[RS1_LSB +: REG_AW]);
            end
            OPC_STORE: begin
                dup_inst[RS1_LSB +: REG_AW] = remap_reg(head[RS1_LSB +: REG_AW]);
                dup_inst[RS2_LSB +: REG_AW] = remap_reg(head[RS2_LSB +: REG_AW]);
            end
            OPC_LUI: begin
                dup_inst[RD_LSB  +: REG_AW] = remap_reg(head[RD_LSB  +: REG_AW]);
            end
            default: ;
        endcase
    end

    // Memory duplicates need the data-side half-space offset
`ifdef QED_MEM_DUP_EN
    assign mem_dup_c = is_mem_op(head[6:0]);
`else
    assign mem_dup_c = 1'b0;
`endif

    // ORIG/DUP sequencer with registered instruction outputs and issue counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ORIG;
            inst_q    <= INST_W'(QED_NOP);
            vld_q     <= 1'b0;
            is_dup_q  <= 1'b0;
            mem_dup_q <= 1'b0;
            ovf_q     <= 1'b0;
            orig_cnt  <= '0;
            dup_cnt   <= '0;
        end else if (active) begin
            case (state)
                ST_ORIG: begin
                    is_dup_q  <= 1'b0;
                    mem_dup_q <= 1'b0;
                    if (push) begin
                        inst_q   <= ifu_inst_i;
                        vld_q    <= 1'b1;
                        orig_cnt <= orig_cnt + 1'b1;
                    end else begin
                        inst_q <= INST_W'(QED_NOP);
                        vld_q  <= 1'b0;
                    end
                    if (drop) ovf_q <= 1'b1;
                    // A same-cycle push counts towards "something to replay"
                    if (exec_dup_i && (push || !fifo_empty)) state <= ST_DUP;
                end
                ST_DUP: begin
                    inst_q    <= dup_inst;
                    vld_q     <= 1'b1;
                    is_dup_q  <= 1'b1;
                    mem_dup_q <= mem_dup_c;
                    dup_cnt   <= dup_cnt + 1'b1;
                    if (fifo_cnt == CW'(1)) state <= ST_ORIG;
                end
                default: state <= ST_ORIG;
            endcase
        end
    end

    assign qed_inst_o    = inst_q;
    assign qed_vld_o     = vld_q;
    assign qed_is_dup_o  = is_dup_q;
    assign qed_mem_dup_o = mem_dup_q;
    assign overflow_o    = ovf_q;
    assign fifo_cnt_o    = fifo_cnt;
    assign qed_ready_o   = (orig_cnt == dup_cnt) && fifo_empty && (state == ST_ORIG);

endmodule

// File: tb/tb_qed_dup_engine.sv
// Bench for qed_dup_engine: queue-based reference model, per-cycle compare, directed literal pins, random traffic.
// Latency: model predicts registered outputs one edge after inputs are sampled.
// Backpressure: exercises stall, ena, full FIFO and overflow.
module tb_qed_dup_engine;

    localparam int INST_W     = 32;
    localparam int DEPTH      = 16;
    localparam int REG_AW     = 5;
    localparam int DUP_OFFSET = 16;
    localparam int CNT_W      = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [31:0] ifu_inst_i = '0;
    logic        ifu_vld_i = 1'b0;
    logic        exec_dup_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        ifu_rdy_o;
    logic [31:0] qed_inst_o;
    logic        qed_vld_o;
    logic        qed_is_dup_o;
    logic        qed_mem_dup_o;
    logic [4:0]  fifo_cnt_o;
    logic        qed_ready_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    qed_dup_engine #(
        .INST_W     (INST_W),
        .DEPTH      (DEPTH),
        .REG_AW     (REG_AW),
        .DUP_OFFSET (DUP_OFFSET),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .ifu_inst_i    (ifu_inst_i),
        .ifu_vld_i     (ifu_vld_i),
        .ifu_rdy_o     (ifu_rdy_o),
        .exec_dup_i    (exec_dup_i),
        .stall_i       (stall_i),
        .qed_inst_o    (qed_inst_o),
        .qed_vld_o     (qed_vld_o),
        .qed_is_dup_o  (qed_is_dup_o),
        .qed_mem_dup_o (qed_mem_dup_o),
        .fifo_cnt_o    (fifo_cnt_o),
        .qed_ready_o   (qed_ready_o),
        .overflow_o    (overflow_o)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    bit          m_dup   = 1'b0;
    logic [15:0] m_ocnt  = '0;
    logic [15:0] m_dcnt  = '0;
    logic [31:0] e_inst  = NOP;
    bit          e_vld   = 1'b0;
    bit          e_isdup = 1'b0;
    bit          e_mem   = 1'b0;
    bit          e_ovf   = 1'b0;

    function automatic bit m_legal(input logic [31:0] i);
        int rd  = int'(i[11:7]);
        int rs1 = int'(i[19:15]);
        int rs2 = int'(i[24:20]);
        case (i[6:0])
            7'h33: return rd < DUP_OFFSET && rs1 < DUP_OFFSET && rs2 < DUP_OFFSET;
            7'h13: return rd < DUP_OFFSET && rs1 < DUP_OFFSET;
            7'h37: return rd < DUP_OFFSET;
`ifdef QED_MEM_DUP_EN
            7'h03: return rd < DUP_OFFSET && rs1 < DUP_OFFSET;
            7'h23: return rs1 < DUP_OFFSET && rs2 < DUP_OFFSET;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_is_mem(input logic [31:0] i);
`ifdef QED_MEM_DUP_EN
        return (i[6:0] == 7'h03) || (i[6:0] == 7'h23);
`else
        return (i[6:0] == 7'h7f) && 1'b0;
`endif
    endfunction

    // Legal fields are below DUP_OFFSET, so adding the offset in place never carries into a neighbour
    function automatic logic [31:0] m_remap(input logic [31:0] i);
        bit u_rd = 0, u_rs1 = 0, u_rs2 = 0;
        logic [31:0] add = 0;
        case (i[6:0])
            7'h33:        begin u_rd = 1; u_rs1 = 1; u_rs2 = 1; end
            7'h13, 7'h03: begin u_rd = 1; u_rs1 = 1; end
            7'h23:        begin u_rs1 = 1; u_rs2 = 1; end
            7'h37:        u_rd = 1;
            default: ;
        endcase
        if (u_rd  && i[11:7]  != 0) add = add + (32'(DUP_OFFSET) << 7);
        if (u_rs1 && i[19:15] != 0) add = add + (32'(DUP_OFFSET) << 15);
        if (u_rs2 && i[24:20] != 0) add = add + (32'(DUP_OFFSET) << 20);
        return i + add;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [31:0] h;
        if (rst) begin
            mq.delete();
            m_dup = 0; m_ocnt = 0; m_dcnt = 0;
            e_inst = NOP; e_vld = 0; e_isdup = 0; e_mem = 0; e_ovf = 0;
        end else if (ena && !stall_i) begin
            if (!m_dup) begin
                e_isdup = 0; e_mem = 0;
                e_inst = NOP; e_vld = 0;
                if (ifu_vld_i && m_legal(ifu_inst_i)) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(ifu_inst_i);
                        e_inst = ifu_inst_i; e_vld = 1;
                        m_ocnt = m_ocnt + 1;
                    end else begin
                        e_ovf = 1;
                    end
                end
                if (exec_dup_i && mq.size() > 0) m_dup = 1;
            end else begin
                h = mq.pop_front();
                e_inst = m_remap(h); e_vld = 1; e_isdup = 1; e_mem = m_is_mem(h);
                m_dcnt = m_dcnt + 1;
                if (mq.size() == 0) m_dup = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("inst",     qed_inst_o,    e_inst);
        chk("vld",      qed_vld_o,     e_vld);
        chk("is_dup",   qed_is_dup_o,  e_isdup);
        chk("mem_dup",  qed_mem_dup_o, e_mem);
        chk("fifo_cnt", 32'(fifo_cnt_o), mq.size());
        chk("ready",    qed_ready_o,   (m_ocnt == m_dcnt) && (mq.size() == 0) && !m_dup);
        chk("overflow", overflow_o,    e_ovf);
        chk("ifu_rdy",  ifu_rdy_o,     ena && !stall_i && !m_dup && (mq.size() < DEPTH));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic en, input logic v, input logic [31:0] ins, input logic d, input logic s);
        ena = en; ifu_vld_i = v; ifu_inst_i = ins; exec_dup_i = d; stall_i = s;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        ena = 0; ifu_vld_i = 0; exec_dup_i = 0; stall_i = 0;
        rst = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  f7;
        logic [6:0]  bad;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        r   = $urandom;
        if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 2))
                0:       rd[4]  = 1'b1;
                1:       rs1[4] = 1'b1;
                default: rs2[4] = 1'b1;
            endcase
        end
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'h01;
        endcase
        case ($urandom_range(0, 4))
            0:       bad = 7'h6f;
            1:       bad = 7'h67;
            2:       bad = 7'h17;
            3:       bad = 7'h73;
            default: bad = 7'h0f;
        endcase
        case ($urandom_range(0, 9))
            0, 1:    return {f7, rs2, rs1, r[14:12], rd, 7'h33};
            2, 3:    return {r[31:20], rs1, r[14:12], rd, 7'h13};
            4:       return {r[31:12], rd, 7'h37};
            5:       return {r[31:20], rs1, 3'b010, rd, 7'h03};
            6:       return {r[31:25], rs2, rs1, 3'b010, r[11:7], 7'h23};
            7:       return {r[31:7], 7'h63};
            8:       return {r[31:7], bad};
            default: return r;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;

        // add x1,x2,x3 then its duplicate
        cyc(1, 1, 32'h003100B3, 1, 0);
        chk("t1_orig", qed_inst_o, 32'h003100B3);
        idle(1);
        chk("t1_dup",    qed_inst_o,   32'h013908B3);
        chk("t1_isdup",  qed_is_dup_o, 1);
        chk("t1_vld",    qed_vld_o,    1);
        chk("t1_ready",  qed_ready_o,  1);

        // beq is filtered
        cyc(1, 1, 32'h00208063, 0, 0);
        chk("t2_inst", qed_inst_o, NOP);
        chk("t2_vld",  qed_vld_o,  0);
        chk("t2_cnt",  32'(fifo_cnt_o), 0);

        // addi x0,x5,1: rd x0 untouched, rs1 5->21
        cyc(1, 1, 32'h00128013, 1, 0);
        idle(1);
        chk("t4_dup", qed_inst_o, 32'h001A8013);

        // four entries, stall half-way through the replay
        cyc(1, 1, 32'h003100B3, 0, 0);
        cyc(1, 1, 32'h00128013, 0, 0);
        cyc(1, 1, 32'h12345037, 0, 0);
        cyc(1, 1, 32'h40208133, 1, 0);
        idle(2);
        chk("t5_cnt2",  32'(fifo_cnt_o), 2);
        chk("t5_inst2", qed_inst_o, 32'h001A8013);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("t5_frz_cnt",  32'(fifo_cnt_o), 2);
        chk("t5_frz_inst", qed_inst_o, 32'h001A8013);
        chk("t5_frz_rdy",  ifu_rdy_o, 0);
        idle(1);
        chk("t5_inst3", qed_inst_o, 32'h12345037);
        idle(1);
        chk("t5_inst4", qed_inst_o, 32'h41288933);
        chk("t5_ready", qed_ready_o, 1);
        chk("t5_cnt0",  32'(fifo_cnt_o), 0);

        // lw x1,0(x2)
        cyc(1, 1, 32'h00012083, 1, 0);
`ifdef QED_MEM_DUP_EN
        idle(1);
        chk("t6_dup", qed_inst_o,    32'h00092883);
        chk("t6_mem", qed_mem_dup_o, 1);
`else
        chk("t6_inst", qed_inst_o, NOP);
        chk("t6_vld",  qed_vld_o,  0);
        idle(1);
        chk("t6_mem",  qed_mem_dup_o, 0);
`endif

        // fill, overflow, drain, reset clears the sticky flag
        for (int k = 0; k < DEPTH; k++)
            cyc(1, 1, {12'(k), 5'(k % 16), 3'b000, 5'(k % 16), 7'h13}, 0, 0);
        chk("t3_full_cnt", 32'(fifo_cnt_o), DEPTH);
        chk("t3_rdy",      ifu_rdy_o, 0);
        cyc(1, 1, 32'h003100B3, 0, 0);
        chk("t3_nop", qed_inst_o, NOP);
        chk("t3_ovf", overflow_o, 1);
        cyc(1, 0, 0, 1, 0);
        idle(DEPTH);
        chk("t3_ovf_sticky", overflow_o, 1);
        chk("t3_ready",      qed_ready_o, 1);
        do_reset();
        chk("t3_ovf_clr", overflow_o, 0);
        chk("rst_inst",   qed_inst_o, NOP);

        // reset in the middle of a replay
        cyc(1, 1, 32'h003100B3, 0, 0);
        cyc(1, 1, 32'h00128013, 0, 0);
        cyc(1, 1, 32'h40208133, 1, 0);
        idle(1);
        do_reset();
        chk("mid_rst_cnt",   32'(fifo_cnt_o), 0);
        chk("mid_rst_isdup", qed_is_dup_o, 0);
        chk("mid_rst_ready", qed_ready_o, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, rand_inst(),
                $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end
        idle(DEPTH + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
